// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and default width for seq_divider.
package seq_divider_pkg;

  // Default divisor / quotient / remainder width; the dividend is twice this.
  localparam int DIV_N = 8;

  // Controller states of the divider.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational radix-2 restoring division step.
// The partial remainder is shifted left with the next dividend bit appended,
// then the divisor magnitude is trial-subtracted. A non-negative result is
// kept and produces a quotient bit of 1; otherwise the shifted value is kept.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   prem,
  input  logic         din,
  input  logic [N-1:0] dvs,
  output logic [N:0]   prem_next,
  output logic         qbit
);

  logic [N+1:0] shifted;
  logic [N:0]   diff;

  assign shifted = {prem, din};
  // The kept difference is always below dvs, so N+1 bits hold it exactly.
  assign diff    = shifted[N:0] - {1'b0, dvs};
  assign qbit    = (shifted >= {2'b00, dvs});

  assign prem_next = qbit ? diff : shifted[N:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, 2N-bit dividend / N-bit divisor.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (magnitude conversion, sign fix-up and quotient range check); without it
// the operands are unsigned and overflow is only the up-front CHECK test.
// Handshake: start (with dividend/divisor) is accepted only in IDLE; finish
// pulses for one cycle when quotient/remainder/ovf/dz are valid, and those
// results hold until the next accepted start clears them.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           finish,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           dz
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  // {prem_q, lo_q} is the shifting remainder/dividend pair; quotient bits
  // enter lo_q from the bottom as dividend bits leave from the top.
  logic [N:0]    prem_q;
  logic [N-1:0]  lo_q;
  logic [N-1:0]  dvs_q;
  logic          finish_q, ovf_q, dz_q;
  logic [N-1:0]  quot_q, rem_q;

  logic [N:0]     step_rem;
  logic           step_q;
  logic [2*N-1:0] dvd_abs;
  logic [N-1:0]   dvs_abs;
  logic [N-1:0]   q_mag, q_fix, r_fix;
  logic           range_ovf;
  logic           check_dz, check_ovf, last_step;

  assign check_dz  = (dvs_q == '0);
  assign check_ovf = (prem_q >= {1'b0, dvs_q});
  assign last_step = (cnt_q == '0);
  assign q_mag     = {lo_q[N-2:0], step_q};

  div_step #(.N(N)) u_step (
    .prem      (prem_q),
    .din       (lo_q[N-1]),
    .dvs       (dvs_q),
    .prem_next (step_rem),
    .qbit      (step_q)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [N-1:0] MAG_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MAG_NEG = {1'b1, {(N-1){1'b0}}};

  logic q_neg_q, r_neg_q;

  // The most negative operands negate onto their own bit pattern, which is
  // exactly the correct unsigned magnitude.
  assign dvd_abs = dividend[2*N-1] ? -dividend : dividend;
  assign dvs_abs = divisor[N-1]    ? -divisor  : divisor;

  assign q_fix     = q_neg_q ? -q_mag : q_mag;
  assign r_fix     = r_neg_q ? -step_rem[N-1:0] : step_rem[N-1:0];
  assign range_ovf = q_neg_q ? (q_mag > MAG_NEG) : (q_mag > MAG_POS);

  // Capture result signs together with the operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      q_neg_q <= dividend[2*N-1] ^ divisor[N-1];
      r_neg_q <= dividend[2*N-1];
    end
  end
`else
  assign dvd_abs   = dividend;
  assign dvs_abs   = divisor;
  assign q_fix     = q_mag;
  assign r_fix     = step_rem[N-1:0];
  assign range_ovf = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: error checks short-cut straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CHECK;
      CHECK:   state_d = (check_dz || check_ovf) ? DONE : ITER;
      ITER:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iterations, and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      prem_q   <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            prem_q <= {1'b0, dvd_abs[2*N-1:N]};
            lo_q   <= dvd_abs[N-1:0];
            dvs_q  <= dvs_abs;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
          end
        end
        CHECK: begin
          if (check_dz) begin
            dz_q     <= 1'b1;
            finish_q <= 1'b1;
          end else if (check_ovf) begin
            ovf_q    <= 1'b1;
            finish_q <= 1'b1;
          end else begin
            cnt_q <= CNT_INIT;
          end
        end
        ITER: begin
          prem_q <= step_rem;
          lo_q   <= q_mag;
          if (last_step) begin
            finish_q <= 1'b1;
            ovf_q    <= range_ovf;
            quot_q   <= range_ovf ? '0 : q_fix;
            rem_q    <= range_ovf ? '0 : r_fix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign finish    = finish_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule
